// File: rtl/fc_sched.sv
// rtl/fc_sched.sv - fully-connected layer sequencer: weight load, accumulator clear, N_W MAC beats, result handoff
module fc_sched #(
   parameter int N_W     = 16,
   parameter int TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       reload,
   output logic       load,
   input  logic       load_done,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [3:0] w_sel,
   output logic       mac_clr,
   output logic       mac_en,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       busy,
   output logic       done,
   output logic       err
);

   localparam logic [3:0] LAST_BEAT = 4'(N_W - 1);
   localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_WAIT_LD = 3'd2,
      S_CLR     = 3'd3,
      S_RUN     = 3'd4,
      S_OUT     = 3'd5
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] tmo_q, tmo_d;
   logic       wv_q, wv_d;
   logic       err_q, err_d;
   logic [7:0] tmo_inc;

   assign tmo_inc = tmo_q + 8'd1;

   // State and bookkeeping registers; reset drops everything back to a cold IDLE
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         tmo_q   <= 8'd0;
         wv_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tmo_q   <= tmo_d;
         wv_q    <= wv_d;
         err_q   <= err_d;
      end
   end

   // Next-state logic, including beat counter, load timeout and weights-valid tracking
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tmo_d   = tmo_q;
      wv_d    = wv_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               err_d   = 1'b0;
               state_d = (!wv_q || reload) ? S_LOAD : S_CLR;
            end
         end
         S_LOAD: begin
            tmo_d   = 8'd0;
            state_d = S_WAIT_LD;
         end
         S_WAIT_LD: begin
            if (load_done) begin
               wv_d    = 1'b1;
               state_d = S_CLR;
            end else begin
               tmo_d = tmo_inc;
               // Give up once the loader has had TIMEOUT cycles; weights keep their old validity
               if (tmo_inc == TMO_LIMIT) begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end
            end
         end
         S_CLR: begin
            cnt_d   = 4'd0;
            state_d = S_RUN;
         end
         S_RUN: begin
            if (in_valid) begin
               // Last beat leaves cnt parked at N_W-1 rather than wrapping
               if (cnt_q == LAST_BEAT) begin
                  state_d = S_OUT;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
         end
         S_OUT: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output decode; all strobes are zero outside the state that owns them
   always_comb begin
      load      = 1'b0;
      mac_clr   = 1'b0;
      in_ready  = 1'b0;
      mac_en    = 1'b0;
      w_sel     = 4'd0;
      out_valid = 1'b0;
      done      = 1'b0;
      busy      = (state_q != S_IDLE);
      err       = err_q;
      case (state_q)
         S_LOAD: begin
            load = 1'b1;
         end
         S_CLR: begin
            mac_clr = 1'b1;
         end
         S_RUN: begin
            in_ready = 1'b1;
            w_sel    = cnt_q;
            mac_en   = in_valid;
         end
         S_OUT: begin
            out_valid = 1'b1;
            done      = out_ready;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_fc_sched.sv
// tb/tb_fc_sched.sv - randomized job-level bench for fc_sched against a transaction timeline model
module tb_fc_sched;

   localparam int NW  = 16;
   localparam int TMO = 4;

   logic       clk;
   logic       rst;
   logic       start;
   logic       reload;
   logic       load;
   logic       load_done;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] w_sel;
   logic       mac_clr;
   logic       mac_en;
   logic       out_valid;
   logic       out_ready;
   logic       busy;
   logic       done;
   logic       err;

   int checks;
   int errors;
   bit m_wv;
   bit m_err;

   fc_sched #(.N_W(NW), .TIMEOUT(TMO)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .reload    (reload),
      .load      (load),
      .load_done (load_done),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .w_sel     (w_sel),
      .mac_clr   (mac_clr),
      .mac_en    (mac_en),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Inputs the controller must ignore in the current state
   task automatic noise();
      start     = 1'($urandom);
      reload    = 1'($urandom);
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      load_done = 1'($urandom);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_load"}, load, 0);
      chk({tag, "_rdy"}, in_ready, 0);
      chk({tag, "_wsel"}, w_sel, 0);
      chk({tag, "_clr"}, mac_clr, 0);
      chk({tag, "_en"}, mac_en, 0);
      chk({tag, "_ov"}, out_valid, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_err"}, err, 0);
   endtask

   // One FC job from the start request; ld_delay >= TMO means the loader never answers,
   // gap_pct < 0 selects an alternating valid pattern, abort_at >= 0 resets at that beat
   task automatic do_job(input bit rl, input int ld_delay, input int gap_pct,
                         input int bp, input int abort_at);
      bit exp_load;
      int b;
      int nen;
      int guard;
      exp_load = !m_wv || rl;

      start = 1'b1; reload = rl;
      in_valid = 1'($urandom); out_ready = 1'($urandom); load_done = 1'($urandom);
      #1;
      chk("idle_busy", busy, 0);
      chk("idle_err", err, 32'(m_err));
      chk("idle_load", load, 0);
      chk("idle_rdy", in_ready, 0);
      m_err = 1'b0;
      tick();

      if (exp_load) begin
         noise();
         #1;
         chk("load_pulse", load, 1);
         chk("load_busy", busy, 1);
         chk("load_err_cleared", err, 32'(m_err));
         chk("load_clr", mac_clr, 0);
         chk("load_rdy", in_ready, 0);
         tick();
         for (int k = 0; k < TMO; k++) begin
            noise();
            load_done = (k >= ld_delay);
            #1;
            chk("wait_load", load, 0);
            chk("wait_rdy", in_ready, 0);
            chk("wait_busy", busy, 1);
            chk("wait_clr", mac_clr, 0);
            tick();
            if (k >= ld_delay) break;
         end
         if (ld_delay >= TMO) begin
            start = 1'b0; reload = 1'b0; load_done = 1'b0;
            #1;
            chk("tmo_busy", busy, 0);
            chk("tmo_err", err, 1);
            chk("tmo_load", load, 0);
            m_err = 1'b1;
            tick();
            return;
         end
         m_wv = 1'b1;
      end

      noise();
      #1;
      chk("clr_pulse", mac_clr, 1);
      chk("clr_rdy", in_ready, 0);
      chk("clr_en", mac_en, 0);
      chk("clr_load", load, 0);
      chk("clr_busy", busy, 1);
      chk("clr_ov", out_valid, 0);
      tick();

      b = 0; nen = 0; guard = 0;
      while (b < NW && guard < 400) begin
         noise();
         if (gap_pct < 0) in_valid = (guard % 2 == 0);
         else in_valid = ($urandom_range(99) >= gap_pct);
         if (b == abort_at) begin
            in_valid = 1'b1;
            start = 1'b0;
            #1;
            rst = 1'b0;
            #1;
            chk_all_zero("abort");
            m_wv = 1'b0;
            m_err = 1'b0;
            tick();
            rst = 1'b1;
            tick();
            #1;
            chk_all_zero("post_abort");
            return;
         end
         #1;
         chk("run_rdy", in_ready, 1);
         chk("run_wsel", w_sel, 32'(b));
         chk("run_en", mac_en, 32'(in_valid));
         chk("run_ov", out_valid, 0);
         chk("run_clr", mac_clr, 0);
         if (mac_en) nen++;
         if (in_valid) b++;
         guard++;
         tick();
      end
      chk("run_beats_bound", b, NW);

      for (int k = 0; k < bp; k++) begin
         noise();
         out_ready = 1'b0;
         #1;
         chk("bp_ov", out_valid, 1);
         chk("bp_rdy", in_ready, 0);
         chk("bp_en", mac_en, 0);
         chk("bp_done", done, 0);
         chk("bp_busy", busy, 1);
         tick();
      end
      noise();
      out_ready = 1'b1;
      #1;
      chk("out_ov", out_valid, 1);
      chk("out_done", done, 1);
      chk("out_rdy", in_ready, 0);
      tick();

      start = 1'b0; reload = 1'b0; out_ready = 1'($urandom);
      #1;
      chk("end_busy", busy, 0);
      chk("end_ov", out_valid, 0);
      chk("end_done", done, 0);
      chk("end_err", err, 0);
      chk("mac_en_total", nen, NW);
      tick();
   endtask

   initial begin
      checks = 0; errors = 0;
      m_wv = 1'b0; m_err = 1'b0;
      rst = 1'b0; start = 1'b0; reload = 1'b0; load_done = 1'b0;
      in_valid = 1'b0; out_ready = 1'b0;
      #2;
      chk_all_zero("reset");
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      tick();

      // Cold start, loader answers immediately, back-to-back beats, no backpressure
      do_job(1'b0, 0, 0, 0, -1);
      // Warm start, random gaps
      do_job(1'b0, 0, 30, 0, -1);
      // Alternating valid with five cycles of backpressure
      do_job(1'b0, 0, -1, 5, -1);
      // Forced reload with a slow loader
      do_job(1'b1, 2, 20, 2, -1);
      // Reset in the middle of RUN at beat 7
      do_job(1'b0, 0, 0, 0, 7);
      // Cold after reset, loader never answers
      do_job(1'b0, 99, 0, 0, -1);
      // Next start clears err and reloads
      do_job(1'b0, 1, 10, 1, -1);

      for (int j = 0; j < 24; j++) begin
         do_job(1'($urandom), $urandom_range(0, 5), $urandom_range(0, 60),
                $urandom_range(0, 4),
                ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
